// File: rtl/trace_stream_receiver.sv
// -----------------------------------------------------------------------------
// trace_stream_receiver
//
// Purpose:
//   AXI-Stream slave terminating the {pc, instr} trace stream. Accepted beats
//   go into a 2-entry skid FIFO and are presented on a valid/ready trace port.
//   In parallel the beat stream is checked against the programmed packet
//   length (tlast_interval) and the WFI end-of-program marker is detected.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   S_AXIS_tvalid/tready/tdata/tlast   AXI-Stream slave, tdata = {pc, instr}
//   tlast_interval      expected beats per packet, 0 disables framing checks
//   out_valid/out_ready valid/ready handshake of the trace port
//   out_pc/out_instr/out_last  head FIFO entry
//   program_finished    sticky, a WFI beat has been accepted
//   pkt_count/beat_count  accepted tlast beats / accepted beats (wrapping)
//   err_tlast_early/err_tlast_missing  sticky framing errors
//   clear_status        clears counters, flags, framing index and FSM state
// -----------------------------------------------------------------------------
module trace_stream_receiver #(
   parameter int XLEN           = 64,
   parameter int AXI_DATA_WIDTH = XLEN + 32,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      S_AXIS_tvalid,
   output logic                      S_AXIS_tready,
   input  logic [AXI_DATA_WIDTH-1:0] S_AXIS_tdata,
   input  logic                      S_AXIS_tlast,
   input  logic [31:0]               tlast_interval,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [XLEN-1:0]           out_pc,
   output logic [31:0]               out_instr,
   output logic                      out_last,
   output logic                      program_finished,
   output logic [CNT_WIDTH-1:0]      pkt_count,
   output logic [CNT_WIDTH-1:0]      beat_count,
   output logic                      err_tlast_early,
   output logic                      err_tlast_missing,
   input  logic                      clear_status
);

   localparam logic [31:0] WFI_INSTR = 32'h0000_0001;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_STREAMING = 2'd1,
      ST_FINISHED  = 2'd2
   } state_t;

   // handshakes and beat decode
   logic            accept_s;
   logic            pop_s;
   logic [XLEN-1:0] in_pc_s;
   logic [31:0]     in_instr_s;
   logic            is_wfi_s;

   // skid FIFO: head entry doubles as the output register
   logic [1:0]      occ_r;
   logic [1:0]      occ_next_s;
   logic [XLEN-1:0] head_pc_r;
   logic [31:0]     head_instr_r;
   logic            head_last_r;
   logic [XLEN-1:0] tail_pc_r;
   logic [31:0]     tail_instr_r;
   logic            tail_last_r;
   logic            tready_r;
   logic            out_valid_r;

   // framing, counters, status
   logic [31:0]          idx_r;
   logic [31:0]          idx_base_s;
   logic [31:0]          idx_next_s;
   logic [31:0]          interval_last_s;
   logic                 framing_on_s;
   logic                 early_set_s;
   logic                 miss_set_s;
   logic                 err_early_r;
   logic                 err_miss_r;
   logic [CNT_WIDTH-1:0] beat_count_r;
   logic [CNT_WIDTH-1:0] pkt_count_r;
   logic [CNT_WIDTH-1:0] beat_base_s;
   logic [CNT_WIDTH-1:0] pkt_base_s;

   // FSM
   state_t state_r;
   state_t state_base_s;
   state_t state_next_s;
   logic   finished_s;

   assign accept_s   = S_AXIS_tvalid & tready_r;
   assign pop_s      = out_valid_r & out_ready;
   assign in_pc_s    = S_AXIS_tdata[AXI_DATA_WIDTH-1:32];
   assign in_instr_s = S_AXIS_tdata[31:0];
   assign is_wfi_s   = (in_instr_s == WFI_INSTR);

   // FIFO occupancy after this edge's push/pop
   always_comb begin
      occ_next_s = occ_r;
      case ({accept_s, pop_s})
         2'b10:   occ_next_s = occ_r + 2'd1;
         2'b01:   occ_next_s = occ_r - 2'd1;
         default: occ_next_s = occ_r;
      endcase
   end

   // FIFO storage, occupancy and registered tready/out_valid
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_r        <= 2'd0;
         head_pc_r    <= '0;
         head_instr_r <= 32'd0;
         head_last_r  <= 1'b0;
         tail_pc_r    <= '0;
         tail_instr_r <= 32'd0;
         tail_last_r  <= 1'b0;
         tready_r     <= 1'b0;
         out_valid_r  <= 1'b0;
      end else begin
         case ({accept_s, pop_s})
            2'b10: begin
               // empty: new beat becomes head; otherwise it queues behind
               if (occ_r == 2'd0) begin
                  head_pc_r    <= in_pc_s;
                  head_instr_r <= in_instr_s;
                  head_last_r  <= S_AXIS_tlast;
               end else begin
                  tail_pc_r    <= in_pc_s;
                  tail_instr_r <= in_instr_s;
                  tail_last_r  <= S_AXIS_tlast;
               end
            end
            2'b01: begin
               if (occ_r == 2'd2) begin
                  head_pc_r    <= tail_pc_r;
                  head_instr_r <= tail_instr_r;
                  head_last_r  <= tail_last_r;
               end else begin
                  head_pc_r    <= head_pc_r;
               end
            end
            2'b11: begin
               // push+pop: older tail advances before the new beat lands
               if (occ_r == 2'd2) begin
                  head_pc_r    <= tail_pc_r;
                  head_instr_r <= tail_instr_r;
                  head_last_r  <= tail_last_r;
                  tail_pc_r    <= in_pc_s;
                  tail_instr_r <= in_instr_s;
                  tail_last_r  <= S_AXIS_tlast;
               end else begin
                  head_pc_r    <= in_pc_s;
                  head_instr_r <= in_instr_s;
                  head_last_r  <= S_AXIS_tlast;
               end
            end
            default: begin
               head_pc_r <= head_pc_r;
            end
         endcase
         occ_r       <= occ_next_s;
         tready_r    <= (occ_next_s < 2'd2);
         out_valid_r <= (occ_next_s != 2'd0);
      end
   end

   // framing check; clear_status is applied first so a same-cycle beat counts on top
   always_comb begin
      idx_base_s      = clear_status ? 32'd0 : idx_r;
      interval_last_s = tlast_interval - 32'd1;
      framing_on_s    = (tlast_interval != 32'd0);
      idx_next_s      = idx_base_s;
      early_set_s     = 1'b0;
      miss_set_s      = 1'b0;
      if (accept_s) begin
         if (S_AXIS_tlast) begin
            idx_next_s  = 32'd0;
            // a WFI beat may legally close a packet short
            early_set_s = framing_on_s & (idx_base_s != interval_last_s) & ~is_wfi_s;
         end else if (framing_on_s && (idx_base_s == interval_last_s)) begin
            idx_next_s  = 32'd0;
            miss_set_s  = 1'b1;
         end else begin
            idx_next_s  = idx_base_s + 32'd1;
         end
         // WFI must end its packet; without tlast it is a missing-tlast error
         if (is_wfi_s && !S_AXIS_tlast) begin
            miss_set_s = 1'b1;
         end else begin
            miss_set_s = miss_set_s;
         end
      end else begin
         idx_next_s = idx_base_s;
      end
   end

   // counter bases after a possible clear
   always_comb begin
      if (clear_status) begin
         beat_base_s = '0;
         pkt_base_s  = '0;
      end else begin
         beat_base_s = beat_count_r;
         pkt_base_s  = pkt_count_r;
      end
   end

   // framing index, sticky flags and wrapping counters
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_r        <= 32'd0;
         err_early_r  <= 1'b0;
         err_miss_r   <= 1'b0;
         beat_count_r <= '0;
         pkt_count_r  <= '0;
      end else begin
         idx_r        <= idx_next_s;
         err_early_r  <= (err_early_r & ~clear_status) | early_set_s;
         err_miss_r   <= (err_miss_r & ~clear_status) | miss_set_s;
         beat_count_r <= beat_base_s + {{(CNT_WIDTH-1){1'b0}}, accept_s};
         pkt_count_r  <= pkt_base_s + {{(CNT_WIDTH-1){1'b0}}, accept_s & S_AXIS_tlast};
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next state; clear returns to IDLE before a same-cycle beat is applied
   always_comb begin
      state_base_s = clear_status ? ST_IDLE : state_r;
      state_next_s = state_base_s;
      if (accept_s && is_wfi_s) begin
         state_next_s = ST_FINISHED;
      end else if (accept_s && (state_base_s == ST_IDLE)) begin
         state_next_s = ST_STREAMING;
      end else begin
         state_next_s = state_base_s;
      end
   end

   // FSM outputs
   always_comb begin
      finished_s = 1'b0;
      case (state_r)
         ST_FINISHED: finished_s = 1'b1;
         default:     finished_s = 1'b0;
      endcase
   end

   assign S_AXIS_tready     = tready_r;
   assign out_valid         = out_valid_r;
   assign out_pc            = head_pc_r;
   assign out_instr         = head_instr_r;
   assign out_last          = head_last_r;
   assign program_finished  = finished_s;
   assign pkt_count         = pkt_count_r;
   assign beat_count        = beat_count_r;
   assign err_tlast_early   = err_early_r;
   assign err_tlast_missing = err_miss_r;

endmodule

// File: tb/tb_trace_stream_receiver.sv
// -----------------------------------------------------------------------------
// tb_trace_stream_receiver
//
// Self-checking bench: a table of per-cycle input/expected-output records,
// followed by hand-written back-pressure and mid-packet reset sequences.
// Beat payloads are derived from a small id: pc = 0x8000..0 + 8*id,
// instr = 0x100 | id, and id 255 stands for the WFI instruction (32'h1).
// -----------------------------------------------------------------------------
module tb_trace_stream_receiver;

   logic        clk;
   logic        rst;
   logic        s_tvalid;
   logic        s_tready;
   logic [95:0] s_tdata;
   logic        s_tlast;
   logic [31:0] ival;
   logic        o_valid;
   logic        o_ready;
   logic [63:0] o_pc;
   logic [31:0] o_instr;
   logic        o_last;
   logic        prog_fin;
   logic [31:0] pkt_cnt;
   logic [31:0] beat_cnt;
   logic        err_early;
   logic        err_miss;
   logic        clr;

   int n_cmp;
   int n_bad;

   trace_stream_receiver #(
      .XLEN           (64),
      .AXI_DATA_WIDTH (96),
      .CNT_WIDTH      (32)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .S_AXIS_tvalid     (s_tvalid),
      .S_AXIS_tready     (s_tready),
      .S_AXIS_tdata      (s_tdata),
      .S_AXIS_tlast      (s_tlast),
      .tlast_interval    (ival),
      .out_valid         (o_valid),
      .out_ready         (o_ready),
      .out_pc            (o_pc),
      .out_instr         (o_instr),
      .out_last          (o_last),
      .program_finished  (prog_fin),
      .pkt_count         (pkt_cnt),
      .beat_count        (beat_cnt),
      .err_tlast_early   (err_early),
      .err_tlast_missing (err_miss),
      .clear_status      (clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        vld;
      int          id;
      logic        last;
      logic        ordy;
      logic        clr;
      logic [31:0] ival;
      logic        e_rdy;
      logic        e_ov;
      int          e_id;
      logic        e_last;
      int          e_pkt;
      int          e_beat;
      logic        e_early;
      logic        e_miss;
      logic        e_fin;
   } vec_t;

   localparam int NVEC = 38;
   vec_t vecs[NVEC];

   function automatic logic [63:0] pc_of(input int id);
      return 64'h8000_0000_0000_0000 + 64'(id) * 64'd8;
   endfunction

   function automatic logic [31:0] instr_of(input int id);
      if (id == 255) return 32'h0000_0001;
      else           return 32'h0000_0100 | 32'(id);
   endfunction

   function automatic vec_t mk(input int r, input int v, input int id, input int l,
                               input int o, input int c, input int iv,
                               input int er, input int eo, input int eid, input int el,
                               input int ep, input int eb, input int ee, input int em,
                               input int ef);
      vec_t x;
      x.rst = (r != 0);  x.vld = (v != 0);  x.id = id;  x.last = (l != 0);
      x.ordy = (o != 0); x.clr = (c != 0);  x.ival = 32'(iv);
      x.e_rdy = (er != 0); x.e_ov = (eo != 0); x.e_id = eid; x.e_last = (el != 0);
      x.e_pkt = ep; x.e_beat = eb; x.e_early = (ee != 0); x.e_miss = (em != 0);
      x.e_fin = (ef != 0);
      return x;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic v, input int id, input logic l,
                        input logic o, input logic c);
      rst      = r;
      s_tvalid = v;
      s_tdata  = {pc_of(id), instr_of(id)};
      s_tlast  = l;
      o_ready  = o;
      clr      = c;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_head(input string nm, input int id, input logic l);
      chk({nm, " valid"}, 64'(o_valid), 64'd1);
      chk({nm, " pc"}, o_pc, pc_of(id));
      chk({nm, " instr"}, 64'(o_instr), 64'(instr_of(id)));
      chk({nm, " last"}, 64'(o_last), 64'(l));
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      ival  = 32'd4;
      drive(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);

      //            rst v  id  l o c iv | rdy ov eid el pkt beat ee em ef
      // normal stream, interval 4, tlast on beats 4 and 8
      vecs[0]  = mk(1, 0,  0, 0, 1, 0, 4,   0, 0,  0, 0, 0, 0, 0, 0, 0);
      vecs[1]  = mk(0, 1,  1, 0, 1, 0, 4,   1, 0,  0, 0, 0, 0, 0, 0, 0);
      vecs[2]  = mk(0, 1,  1, 0, 1, 0, 4,   1, 1,  1, 0, 0, 1, 0, 0, 0);
      vecs[3]  = mk(0, 1,  2, 0, 1, 0, 4,   1, 1,  2, 0, 0, 2, 0, 0, 0);
      vecs[4]  = mk(0, 1,  3, 0, 1, 0, 4,   1, 1,  3, 0, 0, 3, 0, 0, 0);
      vecs[5]  = mk(0, 1,  4, 1, 1, 0, 4,   1, 1,  4, 1, 1, 4, 0, 0, 0);
      vecs[6]  = mk(0, 1,  5, 0, 1, 0, 4,   1, 1,  5, 0, 1, 5, 0, 0, 0);
      vecs[7]  = mk(0, 1,  6, 0, 1, 0, 4,   1, 1,  6, 0, 1, 6, 0, 0, 0);
      vecs[8]  = mk(0, 1,  7, 0, 1, 0, 4,   1, 1,  7, 0, 1, 7, 0, 0, 0);
      vecs[9]  = mk(0, 1,  8, 1, 1, 0, 4,   1, 1,  8, 1, 2, 8, 0, 0, 0);
      vecs[10] = mk(0, 0,  0, 0, 1, 0, 4,   1, 0,  0, 0, 2, 8, 0, 0, 0);
      // early tlast on beat 2, then a clean packet; flag sticky until clear
      vecs[11] = mk(0, 1,  9, 0, 1, 0, 4,   1, 1,  9, 0, 2, 9, 0, 0, 0);
      vecs[12] = mk(0, 1, 10, 1, 1, 0, 4,   1, 1, 10, 1, 3, 10, 1, 0, 0);
      vecs[13] = mk(0, 1, 11, 0, 1, 0, 4,   1, 1, 11, 0, 3, 11, 1, 0, 0);
      vecs[14] = mk(0, 1, 12, 0, 1, 0, 4,   1, 1, 12, 0, 3, 12, 1, 0, 0);
      vecs[15] = mk(0, 1, 13, 0, 1, 0, 4,   1, 1, 13, 0, 3, 13, 1, 0, 0);
      vecs[16] = mk(0, 1, 14, 1, 1, 0, 4,   1, 1, 14, 1, 4, 14, 1, 0, 0);
      vecs[17] = mk(0, 0,  0, 0, 1, 1, 4,   1, 0,  0, 0, 0, 0, 0, 0, 0);
      // missing tlast: 5 beats, error on beat 4
      vecs[18] = mk(0, 1, 15, 0, 1, 0, 4,   1, 1, 15, 0, 0, 1, 0, 0, 0);
      vecs[19] = mk(0, 1, 16, 0, 1, 0, 4,   1, 1, 16, 0, 0, 2, 0, 0, 0);
      vecs[20] = mk(0, 1, 17, 0, 1, 0, 4,   1, 1, 17, 0, 0, 3, 0, 0, 0);
      vecs[21] = mk(0, 1, 18, 0, 1, 0, 4,   1, 1, 18, 0, 0, 4, 0, 1, 0);
      vecs[22] = mk(0, 1, 19, 0, 1, 0, 4,   1, 1, 19, 0, 0, 5, 0, 1, 0);
      // same stimulus with framing disabled
      vecs[23] = mk(0, 0,  0, 0, 1, 1, 0,   1, 0,  0, 0, 0, 0, 0, 0, 0);
      vecs[24] = mk(0, 1, 20, 0, 1, 0, 0,   1, 1, 20, 0, 0, 1, 0, 0, 0);
      vecs[25] = mk(0, 1, 21, 0, 1, 0, 0,   1, 1, 21, 0, 0, 2, 0, 0, 0);
      vecs[26] = mk(0, 1, 22, 0, 1, 0, 0,   1, 1, 22, 0, 0, 3, 0, 0, 0);
      vecs[27] = mk(0, 1, 23, 0, 1, 0, 0,   1, 1, 23, 0, 0, 4, 0, 0, 0);
      vecs[28] = mk(0, 1, 24, 0, 1, 0, 0,   1, 1, 24, 0, 0, 5, 0, 0, 0);
      // WFI on beat 3 with tlast, interval 8; later beats still delivered
      vecs[29] = mk(0, 0,  0, 0, 1, 1, 8,   1, 0,  0, 0, 0, 0, 0, 0, 0);
      vecs[30] = mk(0, 1, 25, 0, 1, 0, 8,   1, 1, 25, 0, 0, 1, 0, 0, 0);
      vecs[31] = mk(0, 1, 26, 0, 1, 0, 8,   1, 1, 26, 0, 0, 2, 0, 0, 0);
      vecs[32] = mk(0, 1,255, 1, 1, 0, 8,   1, 1,255, 1, 1, 3, 0, 0, 1);
      vecs[33] = mk(0, 1, 27, 0, 1, 0, 8,   1, 1, 27, 0, 1, 4, 0, 0, 1);
      vecs[34] = mk(0, 0,  0, 0, 1, 0, 8,   1, 0,  0, 0, 1, 4, 0, 0, 1);
      // WFI without tlast -> missing
      vecs[35] = mk(0, 1,255, 0, 1, 0, 8,   1, 1,255, 0, 1, 5, 0, 1, 1);
      // clear with a same-cycle accept: counted after the clear
      vecs[36] = mk(0, 1, 28, 0, 1, 1, 4,   1, 1, 28, 0, 0, 1, 0, 0, 0);
      vecs[37] = mk(0, 0,  0, 0, 1, 0, 4,   1, 0,  0, 0, 0, 1, 0, 0, 0);

      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].rst, vecs[i].vld, vecs[i].id, vecs[i].last, vecs[i].ordy, vecs[i].clr);
         ival = vecs[i].ival;
         step();
         chk($sformatf("v%0d tready", i), 64'(s_tready), 64'(vecs[i].e_rdy));
         chk($sformatf("v%0d out_valid", i), 64'(o_valid), 64'(vecs[i].e_ov));
         chk($sformatf("v%0d pkt_count", i), 64'(pkt_cnt), 64'(vecs[i].e_pkt));
         chk($sformatf("v%0d beat_count", i), 64'(beat_cnt), 64'(vecs[i].e_beat));
         chk($sformatf("v%0d err_early", i), 64'(err_early), 64'(vecs[i].e_early));
         chk($sformatf("v%0d err_missing", i), 64'(err_miss), 64'(vecs[i].e_miss));
         chk($sformatf("v%0d finished", i), 64'(prog_fin), 64'(vecs[i].e_fin));
         if (vecs[i].e_ov) begin
            chk($sformatf("v%0d out_pc", i), o_pc, pc_of(vecs[i].e_id));
            chk($sformatf("v%0d out_instr", i), 64'(o_instr), 64'(instr_of(vecs[i].e_id)));
            chk($sformatf("v%0d out_last", i), 64'(o_last), 64'(vecs[i].e_last));
         end
         if (vecs[i].rst) begin
            chk($sformatf("v%0d rst out_pc", i), o_pc, 64'd0);
            chk($sformatf("v%0d rst out_instr", i), 64'(o_instr), 64'd0);
            chk($sformatf("v%0d rst out_last", i), 64'(o_last), 64'd0);
         end
      end

      // back-pressure: out_ready low while three beats are offered
      ival = 32'd4;
      drive(1'b0, 1'b1, 40, 1'b0, 1'b0, 1'b0); step();
      chk("bp1 tready", 64'(s_tready), 64'd1);
      chk_head("bp1 head", 40, 1'b0);
      drive(1'b0, 1'b1, 41, 1'b0, 1'b0, 1'b0); step();
      chk("bp2 tready", 64'(s_tready), 64'd0);
      chk_head("bp2 head", 40, 1'b0);
      chk("bp2 beats", 64'(beat_cnt), 64'd3);
      drive(1'b0, 1'b1, 42, 1'b1, 1'b0, 1'b0); step();
      chk("bp3 tready", 64'(s_tready), 64'd0);
      chk_head("bp3 held head", 40, 1'b0);
      chk("bp3 beats", 64'(beat_cnt), 64'd3);
      drive(1'b0, 1'b1, 42, 1'b1, 1'b1, 1'b0); step();
      chk("bp4 tready", 64'(s_tready), 64'd1);
      chk_head("bp4 head", 41, 1'b0);
      chk("bp4 beats", 64'(beat_cnt), 64'd3);
      step();
      chk_head("bp5 head", 42, 1'b1);
      chk("bp5 beats", 64'(beat_cnt), 64'd4);
      chk("bp5 pkts", 64'(pkt_cnt), 64'd1);
      chk("bp5 err_early", 64'(err_early), 64'd0);
      chk("bp5 err_missing", 64'(err_miss), 64'd0);
      drive(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0); step();
      chk("bp6 out_valid", 64'(o_valid), 64'd0);

      // reset with two entries buffered mid-packet
      drive(1'b0, 1'b1, 50, 1'b0, 1'b0, 1'b0); step();
      drive(1'b0, 1'b1, 51, 1'b0, 1'b0, 1'b0); step();
      chk("rs0 tready", 64'(s_tready), 64'd0);
      chk("rs0 beats", 64'(beat_cnt), 64'd6);
      drive(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0); step();
      chk("rs1 tready", 64'(s_tready), 64'd0);
      chk("rs1 out_valid", 64'(o_valid), 64'd0);
      chk("rs1 out_pc", o_pc, 64'd0);
      chk("rs1 out_instr", 64'(o_instr), 64'd0);
      chk("rs1 beats", 64'(beat_cnt), 64'd0);
      drive(1'b0, 1'b1, 60, 1'b0, 1'b1, 1'b0); step();
      chk("rs2 tready", 64'(s_tready), 64'd1);
      chk("rs2 out_valid", 64'(o_valid), 64'd0);
      step();
      chk_head("rs3 head", 60, 1'b0);
      drive(1'b0, 1'b1, 61, 1'b0, 1'b1, 1'b0); step();
      drive(1'b0, 1'b1, 62, 1'b0, 1'b1, 1'b0); step();
      drive(1'b0, 1'b1, 63, 1'b1, 1'b1, 1'b0); step();
      chk_head("rs4 head", 63, 1'b1);
      chk("rs4 beats", 64'(beat_cnt), 64'd4);
      chk("rs4 pkts", 64'(pkt_cnt), 64'd1);
      chk("rs4 err_early", 64'(err_early), 64'd0);
      chk("rs4 err_missing", 64'(err_miss), 64'd0);
      drive(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0); step();
      chk("rs5 out_valid", 64'(o_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/trace_stream_receiver.md
# trace_stream_receiver

AXI-Stream slave that terminates the trace stream produced by the continuous monitoring system. It accepts 96-bit {pc, instr} beats, buffers them in a 2-entry skid FIFO, and unpacks them onto a valid/ready trace port. In parallel it checks packet framing against the programmed tlast interval and detects end-of-program (WFI). It sits in front of software-side or on-chip trace consumers and in the verification environment as the stream checker.

## Interface
- XLEN, 64, pc field width
- AXI_DATA_WIDTH, XLEN+32, tdata width; layout {pc[XLEN-1:0], instr[31:0]}, instr in bits [31:0]
- CNT_WIDTH, 32, width of beat/packet counters

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- S_AXIS_tvalid  in  1  beat valid
- S_AXIS_tready  out  1  receiver can accept
- S_AXIS_tdata  in  AXI_DATA_WIDTH  {pc, instr}
- S_AXIS_tlast  in  1  last beat of packet
- tlast_interval  in  32  expected beats per packet; 0 disables framing checks
- out_valid  out  1  trace entry available
- out_ready  in  1  consumer accepts entry
- out_pc  out  XLEN  pc of head entry
- out_instr  out  32  instr of head entry
- out_last  out  1  tlast of head entry
- program_finished  out  1  sticky: WFI beat accepted
- pkt_count  out  CNT_WIDTH  packets (tlast beats) accepted
- beat_count  out  CNT_WIDTH  total beats accepted
- err_tlast_early  out  1  sticky framing error
- err_tlast_missing  out  1  sticky framing error
- clear_status  in  1  clears sticky flags and counters

## Operation
- Accept = S_AXIS_tvalid & S_AXIS_tready; pop = out_valid & out_ready.
- FIFO: 2 entries of {pc, instr, last}; occupancy 0..2. Push on accept, pop on pop; simultaneous push+pop leaves occupancy unchanged, order preserved.
- out_valid = occupancy != 0; out_pc/out_instr/out_last driven from head entry, held stable while out_valid & !out_ready.
- Framing counter idx (0..tlast_interval-1), advanced per accepted beat:
  - tlast=1: idx <- 0. If tlast_interval!=0, idx != tlast_interval-1 and instr != 32'h0000_0001 -> set err_tlast_early.
  - tlast=0 and tlast_interval!=0 and idx == tlast_interval-1: set err_tlast_missing, idx <- 0.
  - otherwise idx <- idx+1.
- WFI: accepted beat with instr == 32'h0000_0001 is a legal forced packet end; it must carry tlast, else err_tlast_missing set.
- State machine: IDLE (no beat since reset/clear) -> STREAMING on first accept -> FINISHED on accepted WFI beat. In FINISHED beats are still accepted, buffered and counted; program_finished = (state == FINISHED). clear_status -> IDLE.
- Counters: beat_count +1 per accept, pkt_count +1 per accepted tlast beat; both wrap modulo 2^CNT_WIDTH.
- clear_status: zeroes counters, idx, error flags, program_finished; FIFO contents untouched. Accept in same cycle as clear_status is counted after clear (counter = 1).

## Timing
- Reset (rst=1 at clock edge): occupancy 0, S_AXIS_tready 0, out_valid 0, out_pc/out_instr/out_last 0, counters 0, flags 0, state IDLE, idx 0.
- S_AXIS_tready registered: next value = (next occupancy < 2) & !rst. First high the cycle after rst deasserts.
- Latency: beat accepted at edge N visible on out_valid/out_* after edge N (cycle N+1); no combinational tdata->out path.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- Back-pressure: out_ready=0 for two accepts -> occupancy 2, tready low next cycle; tready returns high the cycle after a pop.
- Flags, counters, program_finished update on the edge that accepts the beat.
- rst mid-packet: FIFO and idx discarded; next beat starts a new packet at idx 0.

## Test plan
- tlast_interval=4, 8 beats, tlast on beats 4 and 8, out_ready=1 -> 8 entries in order one cycle after acceptance, pkt_count=2, beat_count=8, no errors.
- out_ready=0 while 3 beats offered -> 2 accepted, tready low, third held; raise out_ready -> all 3 delivered in order, none lost or duplicated.
- tlast_interval=4, tlast on beat 2 (instr≠1) -> err_tlast_early=1 after that edge; next 4-beat packet clean, flag stays set until clear_status.
- tlast_interval=4, 5 beats no tlast -> err_tlast_missing set on beat 4; tlast_interval=0 same stimulus -> no error.
- Beat 3 with instr=32'h0000_0001 and tlast, interval 8 -> no error, program_finished=1, pkt_count=1; later beats still delivered.
- rst asserted with occupancy 2 mid-packet -> all outputs 0 next cycle, tready 1 one cycle after release, next packet framed from idx 0.
